// File: rtl/fft4_frame_seq.sv
// fft4_frame_seq: collects a 4-sample frame for the fft4 core, captures its bins and streams X0..X3 out.
// Define FFT4_SEQ_SCALE_EN to store captured bins divided by 4 (arithmetic >>>2, 1/N normalised).
module fft4_frame_seq #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic [1:0]   out_idx,
    output logic         out_last,
    output logic         busy,
    output logic [W-1:0] x0_re,
    output logic [W-1:0] x0_im,
    output logic [W-1:0] x1_re,
    output logic [W-1:0] x1_im,
    output logic [W-1:0] x2_re,
    output logic [W-1:0] x2_im,
    output logic [W-1:0] x3_re,
    output logic [W-1:0] x3_im,
    input  logic [W-1:0] y0_re,
    input  logic [W-1:0] y0_im,
    input  logic [W-1:0] y1_re,
    input  logic [W-1:0] y1_im,
    input  logic [W-1:0] y2_re,
    input  logic [W-1:0] y2_im,
    input  logic [W-1:0] y3_re,
    input  logic [W-1:0] y3_im
);

    localparam logic [1:0] LOAD   = 2'd0;
    localparam logic [1:0] CAPT   = 2'd1;
    localparam logic [1:0] UNLOAD = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] in_cnt_q, in_cnt_d;
    logic [1:0] out_cnt_q, out_cnt_d;

    logic signed [W-1:0] xr_q [4];
    logic signed [W-1:0] xi_q [4];
    logic signed [W-1:0] rr_q [4];
    logic signed [W-1:0] ri_q [4];
    logic signed [W-1:0] yr [4];
    logic signed [W-1:0] yi [4];

    logic in_xfer;
    logic out_xfer;

    function automatic logic signed [W-1:0] scale_fn(input logic signed [W-1:0] v);
`ifdef FFT4_SEQ_SCALE_EN
        return v >>> 2;
`else
        return v;
`endif
    endfunction

    assign yr[0] = y0_re;
    assign yi[0] = y0_im;
    assign yr[1] = y1_re;
    assign yi[1] = y1_im;
    assign yr[2] = y2_re;
    assign yi[2] = y2_im;
    assign yr[3] = y3_re;
    assign yi[3] = y3_im;

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == UNLOAD);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_ready && out_valid;

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        case (state_q)
            LOAD: begin
                if (in_xfer) begin
                    in_cnt_d = in_cnt_q + 2'd1;
                    if (in_cnt_q == 2'd3) begin
                        state_d = CAPT;
                    end
                end
            end
            CAPT: begin
                state_d = UNLOAD;
            end
            UNLOAD: begin
                if (out_xfer) begin
                    out_cnt_d = out_cnt_q + 2'd1;
                    if (out_cnt_q == 2'd3) begin
                        state_d = LOAD;
                    end
                end
            end
            default: begin
                state_d   = LOAD;
                in_cnt_d  = 2'd0;
                out_cnt_d = 2'd0;
            end
        endcase
    end

    // Frame regs change only on LOAD transfers, so the fft4 inputs stay put through CAPT/UNLOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LOAD;
            in_cnt_q  <= 2'd0;
            out_cnt_q <= 2'd0;
            for (int k = 0; k < 4; k++) begin
                xr_q[k] <= '0;
                xi_q[k] <= '0;
                rr_q[k] <= '0;
                ri_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            if (in_xfer) begin
                xr_q[in_cnt_q] <= in_re;
                xi_q[in_cnt_q] <= in_im;
            end
            if (state_q == CAPT) begin
                for (int k = 0; k < 4; k++) begin
                    rr_q[k] <= scale_fn(yr[k]);
                    ri_q[k] <= scale_fn(yi[k]);
                end
            end
        end
    end

    assign out_re   = rr_q[out_cnt_q];
    assign out_im   = ri_q[out_cnt_q];
    assign out_idx  = out_cnt_q;
    assign out_last = out_valid && (out_cnt_q == 2'd3);
    assign busy     = !((state_q == LOAD) && (in_cnt_q == 2'd0));

    assign x0_re = xr_q[0];
    assign x0_im = xi_q[0];
    assign x1_re = xr_q[1];
    assign x1_im = xi_q[1];
    assign x2_re = xr_q[2];
    assign x2_im = xi_q[2];
    assign x3_re = xr_q[3];
    assign x3_im = xi_q[3];

endmodule
